// File: rtl/jt89_mix_pkg.sv
// Shared definitions for the PSG mixing scheduler: FSM state type, attenuation gain ROM and
// datapath widths. Imported by jt89_att_mul and jt89_mix_sched.
package jt89_mix_pkg;

    localparam logic [3:0]  ATT_MUTE = 4'd15;
    localparam int unsigned ACC_W    = 11;
    localparam int unsigned FILT_W   = 12;

    typedef enum logic [3:0] {
        StIdle,
        StAcc0,
        StAcc1,
        StAcc2,
        StAcc3,
        StFiltA,
        StFiltB,
        StFiltC,
        StOut
    } mix_state_e;

    // 2 dB per step, Q0.8 linear gain; index 15 is a hard mute.
    localparam logic [7:0] GAIN_ROM [16] = '{
        8'd255, 8'd203, 8'd161, 8'd128, 8'd102, 8'd81, 8'd64, 8'd51,
        8'd40,  8'd32,  8'd26,  8'd20,  8'd16,  8'd13, 8'd10, 8'd0
    };

endpackage

// File: rtl/jt89_att_mul.sv
// Shared attenuation multiplier: scales a 9-bit amplitude by the gain ROM entry selected by a
// 4-bit attenuation and drops the 8 fractional bits.
// Ports:
//   amp_i  [8:0]  unsigned amplitude
//   att_i  [3:0]  attenuation index (15 = mute)
//   term_o [8:0]  (amp * gain) >> 8, max 509
module jt89_att_mul
    import jt89_mix_pkg::*;
(
    input  logic [8:0] amp_i,
    input  logic [3:0] att_i,
    output logic [8:0] term_o
);

    logic [16:0] prod;

    always_comb begin
        prod   = {8'd0, amp_i} * {9'd0, GAIN_ROM[att_i]};
        term_o = 9'(prod >> 8);
    end

endmodule

// File: rtl/jt89_mix_sched.sv
// Time-multiplexed PSG mixer: once per frame, steps ch0, ch1, ch2 and noise through one shared
// attenuation multiplier into an accumulator, runs a 3-pole smoothing filter one pole per cycle,
// and publishes an 11-bit sample with a one-cen-cycle valid strobe. Owns the CPU-visible
// attenuation registers; pending values become active only at frame start.
// Optional build macro: JT89_MIX_SOLO_EN adds solo_i[3:0] (nonzero = mix only flagged channels).
// Ports:
//   clk_i, rst_ni (async, active low), cen_i (clock enable for all state)
//   ch0_i, ch1_i, ch2_i, noise_i [8:0]  channel amplitudes, sampled in their ACC cycle
//   cfg_we_i, cfg_addr_i [1:0], cfg_att_i [3:0]  attenuation write port (3 = noise)
//   sound_o [10:0]  filtered mix, sample_vld_o  update strobe, busy_o  frame in progress
module jt89_mix_sched
    import jt89_mix_pkg::*;
#(
    parameter int unsigned CLKDIV = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cen_i,
    input  logic [8:0]         ch0_i,
    input  logic [8:0]         ch1_i,
    input  logic [8:0]         ch2_i,
    input  logic [8:0]         noise_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [3:0]         cfg_att_i,
`ifdef JT89_MIX_SOLO_EN
    input  logic [3:0]         solo_i,
`endif
    output logic [ACC_W-1:0]   sound_o,
    output logic               sample_vld_o,
    output logic               busy_o
);

    localparam int unsigned      DivW     = $clog2(CLKDIV);
    localparam logic [DivW-1:0]  DIV_LAST = DivW'(CLKDIV - 1);

    mix_state_e               state_q, state_d;
    logic [DivW-1:0]          div_q, div_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic signed [FILT_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [ACC_W-1:0]         sound_q, sound_d;
    logic                     vld_q, vld_d;
    logic [3:0]               pend_q [4];
    logic [3:0]               pend_d [4];
    logic [3:0]               act_q [4];
    logic [3:0]               act_d [4];

    logic [1:0]  sel_idx;
    logic [8:0]  amp_sel;
    logic [8:0]  term;
    logic [8:0]  term_eff;
    logic [FILT_W:0] sum_ab, sum_bc, sum_cacc;

`ifdef JT89_MIX_SOLO_EN
    logic [3:0] solo_q, solo_d;
`endif

    // Channel select for the shared multiplier, derived from the ACC state.
    always_comb begin
        sel_idx = 2'd0;
        case (state_q)
            StAcc1:  sel_idx = 2'd1;
            StAcc2:  sel_idx = 2'd2;
            StAcc3:  sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
        unique case (sel_idx)
            2'd0: amp_sel = ch0_i;
            2'd1: amp_sel = ch1_i;
            2'd2: amp_sel = ch2_i;
            2'd3: amp_sel = noise_i;
        endcase
    end

    jt89_att_mul u_att_mul (
        .amp_i  (amp_sel),
        .att_i  (act_q[sel_idx]),
        .term_o (term)
    );

`ifdef JT89_MIX_SOLO_EN
    assign term_eff = ((solo_q == 4'd0) || solo_q[sel_idx]) ? term : 9'd0;
`else
    assign term_eff = term;
`endif

    // Filter adds at FILT_W+1 bits; taking [FILT_W:1] is the arithmetic shift right by one.
    assign sum_ab   = {a_q[FILT_W-1], a_q} + {b_q[FILT_W-1], b_q};
    assign sum_bc   = {b_q[FILT_W-1], b_q} + {c_q[FILT_W-1], c_q};
    assign sum_cacc = {c_q[FILT_W-1], c_q} + {{(FILT_W + 1 - ACC_W){1'b0}}, acc_q};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sound_d = sound_q;
        vld_d   = vld_q;
        pend_d  = pend_q;
        act_d   = act_q;
`ifdef JT89_MIX_SOLO_EN
        solo_d  = solo_q;
`endif
        if (cen_i) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DivW'(1);
            vld_d = 1'b0;
            if (cfg_we_i) begin
                pend_d[cfg_addr_i] = cfg_att_i;
            end
            case (state_q)
                StIdle: begin
                    // Frame start only from IDLE, so short CLKDIV skips frames instead of
                    // overlapping them. act_d takes the old pending bank, so a same-cycle write
                    // waits for the next frame.
                    if (div_q == DIV_LAST) begin
                        act_d   = pend_q;
`ifdef JT89_MIX_SOLO_EN
                        solo_d  = solo_i;
`endif
                        state_d = StAcc0;
                    end
                end
                StAcc0: begin
                    acc_d   = ACC_W'(term_eff);
                    state_d = StAcc1;
                end
                StAcc1: begin
                    acc_d   = acc_q + ACC_W'(term_eff);
                    state_d = StAcc2;
                end
                StAcc2: begin
                    acc_d   = acc_q + ACC_W'(term_eff);
                    state_d = StAcc3;
                end
                StAcc3: begin
                    acc_d   = acc_q + ACC_W'(term_eff);
                    state_d = StFiltA;
                end
                // A before B before C: each pole reads its neighbour's previous-frame value.
                StFiltA: begin
                    a_d     = sum_ab[FILT_W:1];
                    state_d = StFiltB;
                end
                StFiltB: begin
                    b_d     = sum_bc[FILT_W:1];
                    state_d = StFiltC;
                end
                StFiltC: begin
                    c_d     = sum_cacc[FILT_W:1];
                    state_d = StOut;
                end
                StOut: begin
                    sound_d = a_q[ACC_W-1:0];
                    vld_d   = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            div_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            sound_q <= '0;
            vld_q   <= 1'b0;
            pend_q  <= '{default: ATT_MUTE};
            act_q   <= '{default: ATT_MUTE};
`ifdef JT89_MIX_SOLO_EN
            solo_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sound_q <= sound_d;
            vld_q   <= vld_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
`ifdef JT89_MIX_SOLO_EN
            solo_q  <= solo_d;
`endif
        end
    end

    assign sound_o      = sound_q;
    assign sample_vld_o = vld_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_jt89_mix_sched.sv
// Self-checking bench for jt89_mix_sched. A frame-level reference model tracks pending/active
// attenuation by counting cen cycles, queues each frame's mix sum at frame start, and applies
// the simultaneous three-pole update when the sample strobe rises.
module tb_jt89_mix_sched;

    localparam int unsigned CLKDIV = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cen_i;
    logic [8:0]  ch0_i, ch1_i, ch2_i, noise_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [3:0]  cfg_att_i;
    logic [10:0] sound_o;
    logic        sample_vld_o;
    logic        busy_o;
`ifdef JT89_MIX_SOLO_EN
    logic [3:0]  solo_i;
`endif

    jt89_mix_sched #(.CLKDIV(CLKDIV)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cen_i        (cen_i),
        .ch0_i        (ch0_i),
        .ch1_i        (ch1_i),
        .ch2_i        (ch2_i),
        .noise_i      (noise_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_att_i    (cfg_att_i),
`ifdef JT89_MIX_SOLO_EN
        .solo_i       (solo_i),
`endif
        .sound_o      (sound_o),
        .sample_vld_o (sample_vld_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int gain_tab [16] = '{255, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 16, 13, 10, 0};
    int pend_m [4];
    int act_m [4];
    int ch_m [4];
    int solo_m = 0;
    int solo_act_m = 0;
    int acc_fifo [$];
    int fa, fb, fc;
    int cen_cnt = 0;
    int clk_cnt = 0;
    int fs_begin = 0;
    int rise_t = 0;
    bit half_cen = 0;
    logic vld_prev = 1'b0;

    function automatic int frame_acc();
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            if (solo_act_m != 0 && ((solo_act_m >> i) & 1) == 0) continue;
            s += (ch_m[i] * gain_tab[act_m[i]]) / 256;
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            pend_m[i] = 15;
            act_m[i]  = 15;
        end
        solo_act_m = 0;
        acc_fifo.delete();
        fa = 0; fb = 0; fc = 0;
        cen_cnt = 0;
    endtask

    task automatic set_ch(input int c0, input int c1, input int c2, input int cn);
        ch_m[0] = c0; ch_m[1] = c1; ch_m[2] = c2; ch_m[3] = cn;
        ch0_i = 9'(c0); ch1_i = 9'(c1); ch2_i = 9'(c2); noise_i = 9'(cn);
    endtask

    task automatic set_solo(input int s);
        solo_m = s;
`ifdef JT89_MIX_SOLO_EN
        solo_i = 4'(s);
`endif
    endtask

    // One clock: pick cen, let the model see this edge, then advance to 1 time unit past it.
    task automatic tick();
        if (half_cen) cen_i = ~cen_i;
        else          cen_i = 1'b1;
        vld_prev = sample_vld_o;
        if (rst_ni && cen_i) begin
            if (cen_cnt % CLKDIV == CLKDIV - 1) begin
                act_m      = pend_m;
                solo_act_m = solo_m;
                acc_fifo.push_back(frame_acc());
                fs_begin   = clk_cnt;
            end
            if (cfg_we_i) pend_m[cfg_addr_i] = cfg_att_i;
            cen_cnt++;
        end
        @(posedge clk_i);
        #1;
        clk_cnt++;
    endtask

    task automatic write_att(input int addr, input int att);
        cfg_we_i   = 1'b1;
        cfg_addr_i = 2'(addr);
        cfg_att_i  = 4'(att);
        tick();
        cfg_we_i   = 1'b0;
    endtask

    // Wait for the next rising sample strobe and compare against the filter model.
    task automatic frame_check(input string tag, output int snd);
        bit got = 0;
        int acc, na, nb, nc;
        logic [10:0] exp_s;
        snd = -1;
        for (int i = 0; i < 4 * CLKDIV + 8; i++) begin
            tick();
            if (sample_vld_o && !vld_prev) begin
                got = 1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL %s: sample_vld did not rise within bound (got 0, required 1)", tag);
            return;
        end
        rise_t = clk_cnt;
        if (acc_fifo.size() == 0) begin
            n_err++;
            $display("FAIL %s: sample_vld rose with no model frame start (got 1, required 0)", tag);
            return;
        end
        acc = acc_fifo.pop_front();
        na = (fa + fb) >>> 1;
        nb = (fb + fc) >>> 1;
        nc = (fc + acc) >>> 1;
        fa = na; fb = nb; fc = nc;
        exp_s = fa[10:0];
        snd = int'(sound_o);
        if (sound_o !== exp_s) begin
            n_err++;
            $display("FAIL %s: sound got %0d required %0d (acc %0d)", tag, sound_o, exp_s, acc);
        end
    endtask

    task automatic test_reset();
        int snd;
        rst_ni = 1'b0;
        half_cen = 1;
        cen_i = 1'b0;
        cfg_we_i = 1'b0; cfg_addr_i = 2'd0; cfg_att_i = 4'd0;
        set_ch(300, 300, 300, 300);
        set_solo(0);
        model_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (sound_o !== 11'd0) begin
                n_err++; $display("FAIL reset_sound: got %0d required 0", sound_o);
            end
            n_cmp++;
            if (sample_vld_o !== 1'b0) begin
                n_err++; $display("FAIL reset_vld: got %b required 0", sample_vld_o);
            end
            n_cmp++;
            if (busy_o !== 1'b0) begin
                n_err++; $display("FAIL reset_busy: got %b required 0", busy_o);
            end
        end
        rst_ni = 1'b1;
        half_cen = 0;
        for (int f = 0; f < 20; f++) frame_check("muted_after_reset", snd);
    endtask

    task automatic test_unity_mix();
        int snd, prev = 0;
        set_ch(100, 100, 100, 100);
        for (int a = 0; a < 4; a++) write_att(a, 0);
        for (int f = 0; f < 40; f++) begin
            frame_check("unity_mix", snd);
            n_cmp++;
            if (snd < prev) begin
                n_err++; $display("FAIL unity_monotonic: got %0d required >= %0d", snd, prev);
            end
            prev = snd;
        end
        // Truncating shifts settle each pole slightly below acc=396.
        n_cmp++;
        if (prev < 393 || prev > 396) begin
            n_err++; $display("FAIL unity_settle: got %0d required 393..396", prev);
        end
    endtask

    task automatic test_step_mute();
        int snd, prev;
        bit seen = 0;
        for (int i = 0; i < 2 * CLKDIV; i++) begin
            tick();
            if (busy_o) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL step_wait_busy: busy got 0 required 1");
        end
        write_att(0, 15);
        frame_check("step_same_frame", prev);
        for (int f = 0; f < 30; f++) begin
            frame_check("step_decay", snd);
            n_cmp++;
            if (snd > prev) begin
                n_err++; $display("FAIL step_monotonic: got %0d required <= %0d", snd, prev);
            end
            prev = snd;
        end
        n_cmp++;
        if (prev < 297 || prev > 298) begin
            n_err++; $display("FAIL step_settle: got %0d required 297..298", prev);
        end
    endtask

    task automatic test_timing();
        int snd, t0;
        half_cen = 0;
        frame_check("timing_sync", snd);
        for (int k = 0; k < 3; k++) begin
            t0 = rise_t;
            n_cmp++;
            if (rise_t - fs_begin != 9) begin
                n_err++;
                $display("FAIL timing_latency: got %0d clk required 9", rise_t - fs_begin);
            end
            tick();
            n_cmp++;
            if (sample_vld_o !== 1'b0) begin
                n_err++; $display("FAIL timing_pulse_width: vld got %b required 0", sample_vld_o);
            end
            frame_check("timing_frame", snd);
            n_cmp++;
            if (rise_t - t0 != 16) begin
                n_err++; $display("FAIL timing_period: got %0d clk required 16", rise_t - t0);
            end
        end
        half_cen = 1;
        frame_check("timing_half_sync", snd);
        for (int k = 0; k < 3; k++) begin
            t0 = rise_t;
            tick();
            n_cmp++;
            if (sample_vld_o !== 1'b1) begin
                n_err++; $display("FAIL timing_vld_frozen: got %b required 1", sample_vld_o);
            end
            tick();
            n_cmp++;
            if (sample_vld_o !== 1'b0) begin
                n_err++; $display("FAIL timing_vld_half_clear: got %b required 0", sample_vld_o);
            end
            frame_check("timing_half_frame", snd);
            n_cmp++;
            if (rise_t - t0 != 32) begin
                n_err++; $display("FAIL timing_half_period: got %0d clk required 32", rise_t - t0);
            end
        end
        half_cen = 0;
    endtask

    task automatic test_async_reset();
        int snd;
        bit seen = 0;
        for (int i = 0; i < 2 * CLKDIV; i++) begin
            tick();
            if (busy_o) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL async_wait_busy: busy got 0 required 1");
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL async_busy: got %b required 0", busy_o);
        end
        n_cmp++;
        if (sound_o !== 11'd0) begin
            n_err++; $display("FAIL async_sound: got %0d required 0", sound_o);
        end
        n_cmp++;
        if (sample_vld_o !== 1'b0) begin
            n_err++; $display("FAIL async_vld: got %b required 0", sample_vld_o);
        end
        model_reset();
        for (int i = 0; i < 3; i++) tick();
        rst_ni = 1'b1;
        for (int f = 0; f < 3; f++) frame_check("async_muted", snd);
    endtask

    task automatic test_random_filter();
        int snd, mode, addr;
        bit hit;
        for (int f = 0; f < 1000; f++) begin
            set_ch($urandom_range(0, 511), $urandom_range(0, 511),
                   $urandom_range(0, 511), $urandom_range(0, 511));
            mode = $urandom_range(0, 3);
            addr = $urandom_range(0, 3);
            if (mode == 1) begin
                write_att(addr, $urandom_range(0, 15));
            end else if (mode == 2) begin
                write_att(addr, $urandom_range(0, 15));
                write_att(addr, $urandom_range(0, 15));
            end else if (mode == 3) begin
                // Land the write on the frame-start edge itself.
                hit = 0;
                for (int i = 0; i < CLKDIV; i++) begin
                    if (cen_cnt % CLKDIV == CLKDIV - 1) begin
                        hit = 1;
                        break;
                    end
                    tick();
                end
                if (hit) write_att(addr, $urandom_range(0, 15));
            end
            frame_check("random_filter", snd);
        end
    endtask

`ifdef JT89_MIX_SOLO_EN
    task automatic test_solo();
        int snd;
        set_solo(4);
        set_ch(400, 400, 200, 400);
        for (int a = 0; a < 4; a++) write_att(a, 0);
        for (int f = 0; f < 10; f++) frame_check("solo", snd);
        set_solo(0);
        for (int f = 0; f < 3; f++) frame_check("solo_off", snd);
    endtask
`endif

    initial begin
        test_reset();
        test_unity_mix();
        test_step_mute();
        test_timing();
        test_async_reset();
        test_random_filter();
`ifdef JT89_MIX_SOLO_EN
        test_solo();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
